// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op codes, FSM state encoding and the iteration count.
package md_pkg;

    localparam int unsigned ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StPrep,
        StCalc,
        StFix
    } state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of the shared multiply/divide datapath: a 33-bit adder used
// either for shift-add multiplication or restoring-division trial subtraction.
module md_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] acc_next
);

    logic [32:0] lhs;
    logic [32:0] rhs;
    logic        cin;
    logic [33:0] sum;

    always_comb begin
        lhs      = '0;
        rhs      = '0;
        cin      = 1'b0;
        acc_next = acc;
        if (is_div) begin
            // Remainder shifted left with the next dividend bit brought in.
            lhs = acc[63:31];
            rhs = ~{1'b0, opnd};
            cin = 1'b1;
        end else begin
            lhs = {1'b0, acc[63:32]};
            rhs = acc[0] ? {1'b0, opnd} : 33'd0;
        end

        sum = {1'b0, lhs} + {1'b0, rhs} + {33'd0, cin};

        if (is_div) begin
            // Carry out of the subtraction means the trial result is non-negative.
            if (sum[33]) begin
                acc_next = {sum[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {acc[62:0], 1'b0};
            end
        end else begin
            acc_next = {sum[32:0], acc[31:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer holding HI/LO, one bit per cycle,
// with MTHI/MTLO writes and a busy/done handshake for the hazard unit.
module mdu_seq #(
    parameter int unsigned ITER = md_pkg::ITER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import md_pkg::*;

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic [4:0]  cnt_q;
    logic        neg_q;
    logic        rneg_q;
    logic        dz_q;

    logic        is_div;
    logic        is_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] acc_step;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign a_mag     = (is_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
    assign b_mag     = (is_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
    assign prod_fix  = neg_q  ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix   = neg_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix   = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    md_step u_step (
        .is_div   (is_div),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        busy    <= 1'b1;
                        state_q <= StPrep;
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                StPrep: begin
                    neg_q   <= is_signed && (a_q[31] ^ b_q[31]);
                    rneg_q  <= is_signed && a_q[31];
                    dz_q    <= is_div && (b_q == 32'd0);
                    // Low half carries the multiplier (mul) or dividend (div).
                    acc_q   <= {32'd0, is_div ? a_mag : b_mag};
                    opnd_q  <= is_div ? b_mag : a_mag;
                    cnt_q   <= '0;
                    state_q <= StCalc;
                end
                StCalc: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(ITER - 1)) state_q <= StFix;
                end
                StFix: begin
                    if (!is_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else if (dz_q) begin
                        hi <= a_q;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed ops push expected HI/LO, a monitor
// compares on every done pulse.
module tb_mdu_seq;

    localparam logic [1:0] T_MULT  = 2'b00;
    localparam logic [1:0] T_MULTU = 2'b01;
    localparam logic [1:0] T_DIV   = 2'b10;
    localparam logic [1:0] T_DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mdu_seq dut (
        .clk   (clk),
        .reset (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
            end
        end
    end

    // Issue one op from IDLE (called #1 after an edge) and follow it to done.
    // poke=1: foreign start at cycle 5; poke=2: MTLO write at cycle 5.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] eh, input logic [31:0] el,
                          input int poke);
        int cyc;
        bit busy_ok;
        op    = o;
        a     = ia;
        b     = ib;
        start = 1'b1;
        sb.push_back('{eh, el});
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
        cyc     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 60) begin
            if (cyc == 5 && poke == 1) begin
                start = 1'b1;
                op    = T_DIVU;
                a     = 32'd9;
                b     = 32'd2;
            end
            if (cyc == 5 && poke == 2) begin
                wr_lo = 1'b1;
                wdata = 32'h0000_1234;
            end
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            wr_lo = 1'b0;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end
        check({name, "_latency"}, cyc, 32'd34);
        check({name, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        check({name, "_busy_fall"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_neg", T_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("divu_b2b", T_DIVU, 32'd100, 32'd7, 32'd2, 32'h0000_000E, 0);
        run_op("div_neg", T_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
        run_op("div_zero", T_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
        run_op("divu_big", T_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 0);
        run_op("mult_min", T_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 0);
        run_op("start_busy", T_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1);
        run_op("wr_busy", T_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 2);

        // MTLO in idle
        wr_lo = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        check("mtlo_idle", lo, 32'h0000_1234);
        check("mtlo_hi_kept", hi, 32'd0);

        // Both strobes together
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'h0000_5555;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        check("mt_both_hi", hi, 32'h0000_5555);
        check("mt_both_lo", lo, 32'h0000_5555);

        // start with wr_hi: write must be dropped
        op    = T_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        start = 1'b1;
        wr_hi = 1'b1;
        wdata = 32'h0000_DEAD;
        sb.push_back('{32'd0, 32'd6});
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_hi = 1'b0;
        check("start_wr_dropped", hi, 32'h0000_5555);
        check("start_wr_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("start_wr_done", {31'd0, done}, 32'd1);

        // Reset in cycle 10 of a MULT (hi/lo currently 0/6)
        op    = T_MULT;
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", {31'd0, done}, 32'd0);

        run_op("multu_after_rst", T_MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 0);

        @(negedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
